t03_vga_timing: RTL
===================

T03_VGA_TIMING -- requirements
Module: t03_vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, H_SYNC, H_BP, defaults 40, 128, 88; horizontal front porch, sync, back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 Parameter V_FP, V_SYNC, V_BP, defaults 1, 4, 23; vertical front porch, sync, back porch in lines.
REQ-005 Parameter SYNC_POL, default 1, sync asserted level (1 = active-high).
REQ-006 clk  input  1  system clock, single clock domain.
REQ-007 nRst  input  1  reset, asynchronous, active-low.
REQ-008 pix_en  input  1  pixel strobe; counters advance only on cycles with pix_en=1.
REQ-009 restart  input  1  synchronous request to return to (0,0).
REQ-010 Hcnt  output  11  current pixel column.
REQ-011 Vcnt  output  11  current line.
REQ-012 hsync, vsync  output  1 each  sync pulses at SYNC_POL level.
REQ-013 active  output  1  high when Hcnt<H_ACTIVE and Vcnt<V_ACTIVE.
REQ-014 line_start, frame_start  output  1 each  single-cycle pulses.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL likewise (628); all arithmetic 11-bit unsigned, totals SHALL be <= 2047.
REQ-016 On a clk edge with pix_en=1: Hcnt increments; at Hcnt=H_TOTAL-1 it wraps to 0 and Vcnt increments; at Vcnt=V_TOTAL-1 with Hcnt wrap, Vcnt wraps to 0.
REQ-017 pix_en=0: Hcnt, Vcnt, hsync, vsync, active hold; line_start and frame_start are 0.
REQ-018 hsync = SYNC_POL when H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vsync analogous on Vcnt.
REQ-019 hsync, vsync, active are registered and decoded from next-state counts, so in every cycle they correspond exactly to the Hcnt/Vcnt presented that same cycle (zero skew).
REQ-020 line_start is 1 for exactly the one clk cycle after a pix_en-qualified Hcnt wrap to 0; frame_start is 1 for the one cycle after a wrap to (0,0); frame_start implies line_start.
REQ-021 restart=1 on a clk edge sets Hcnt=0, Vcnt=0 irrespective of pix_en and asserts line_start and frame_start next cycle; restart has priority over normal advance.
REQ-022 Outputs feed downstream color logic directly; no other latency stages.

Reset
REQ-023 While nRst=0: Hcnt=0, Vcnt=0, hsync=vsync=~SYNC_POL, active=0, line_start=frame_start=0, asynchronously.
REQ-024 First pix_en after nRst release advances to Hcnt=1; active becomes 1 on the first clk edge after release (state (0,0) visible).
REQ-025 Reset asserted mid-frame discards position; no partial-line recovery.

Configuration
REQ-026 Macro T03_VGA_FRAME_CNT_EN defined: extra output frame_cnt [15:0], reset 0, increments on each frame_start cycle, wraps 65535->0, cleared by restart.
REQ-027 Macro undefined: frame_cnt port and its register absent; all other behaviour identical.

Structure
REQ-028 Package t03_vga_pkg holds default timing constants (H_ACTIVE..V_BP), derived H_TOTAL/V_TOTAL, and count width localparam (11).
REQ-029 Sub-module t03_vga_axis_counter (parameters ACTIVE, FP, SYNC, BP, POL; inputs clk, nRst, inc, clr; outputs cnt, sync, act, wrap) instantiated once per axis; vertical inc = pix_en & horizontal wrap.

Verification
REQ-030 Reset then pix_en=1 constant for 1056 cycles -> Hcnt sweeps 0..1055, returns 0, Vcnt=1, line_start pulses once.
REQ-031 Hcnt 840..967 -> hsync=1; Hcnt=839 and 968 -> hsync=0; active=0 for Hcnt>=800.
REQ-032 Full frame 1056*628 = 663168 pix_en cycles -> vsync=1 exactly for Vcnt 601..604, frame_start pulses once on return to (0,0).
REQ-033 pix_en toggled 1/0 alternately -> counts advance every second cycle, no line_start on hold cycles.
REQ-034 restart at (500,300) with pix_en=0 -> next cycle (0,0), frame_start=1, frame_cnt cleared (macro defined).
REQ-035 nRst asserted at (700,200) mid-cycle -> outputs reach reset values without a clk edge.

Source files
------------

// File: rtl/t03_vga_pkg.sv
// Shared timing defaults and count width for the t03 VGA timing generator.
package t03_vga_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned MAX_TOTAL = (1 << CNT_W) - 1;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned H_FP_DEF     = 40;
    localparam int unsigned H_SYNC_DEF   = 128;
    localparam int unsigned H_BP_DEF     = 88;

    localparam int unsigned V_ACTIVE_DEF = 600;
    localparam int unsigned V_FP_DEF     = 1;
    localparam int unsigned V_SYNC_DEF   = 4;
    localparam int unsigned V_BP_DEF     = 23;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/t03_vga_axis_counter.sv
// One display axis: position counter with registered sync/active decoded from
// the next count, so the flags always line up with the count they accompany.
module t03_vga_axis_counter
    import t03_vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF,
    parameter bit          POL    = 1'b1
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sync,
    output logic             act,
    output logic             wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

    if (TOTAL > MAX_TOTAL || TOTAL == 0) begin : g_bad_total
        $error("t03_vga_axis_counter: axis total out of 11-bit range");
    end

    logic [CNT_W-1:0] cnt_nxt;
    logic             sync_nxt;
    logic             act_nxt;

    // Terminal count; combinational so the next axis can chain off it.
    assign wrap = (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end
        sync_nxt = ((cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI)) ? POL : ~POL;
        act_nxt  = (cnt_nxt < ACT_END);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt  <= '0;
            sync <= ~POL;
            act  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            sync <= sync_nxt;
            act  <= act_nxt;
        end
    end

endmodule

// File: rtl/t03_vga_timing.sv
// VGA raster timing generator: pixel-strobed H/V counters, syncs, active and
// line/frame start pulses. Define T03_VGA_FRAME_CNT_EN to add a 16-bit frame counter.
module t03_vga_timing
    import t03_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             pix_en,
    input  logic             restart,
    output logic [CNT_W-1:0] Hcnt,
    output logic [CNT_W-1:0] Vcnt,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
`ifdef T03_VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    logic h_wrap;
    logic v_wrap;
    logic h_act;
    logic v_act;
    logic v_inc;

    assign v_inc = pix_en & h_wrap;

    t03_vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (SYNC_POL)
    ) u_h_axis (
        .clk  (clk),
        .nRst (nRst),
        .inc  (pix_en),
        .clr  (restart),
        .cnt  (Hcnt),
        .sync (hsync),
        .act  (h_act),
        .wrap (h_wrap)
    );

    t03_vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (SYNC_POL)
    ) u_v_axis (
        .clk  (clk),
        .nRst (nRst),
        .inc  (v_inc),
        .clr  (restart),
        .cnt  (Vcnt),
        .sync (vsync),
        .act  (v_act),
        .wrap (v_wrap)
    );

    // Both axis flags are flops updated on the same edge as the counts.
    assign active = h_act & v_act;

    // Start pulses mark the first cycle at column 0 / position (0,0).
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= restart | v_inc;
            frame_start <= restart | (v_inc & v_wrap);
        end
    end

`ifdef T03_VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            frame_cnt <= '0;
        end else if (restart) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'(1);
        end
    end
`endif

endmodule
